// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters (fetch, load), the arbiter and the shared ROM.
// The slave modport is the arbiter's view; the master modport is the requesters'/ROM's view.
interface rom_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, rom_data,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, rom_data,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM: load port has priority,
// but fetch is guaranteed a grant after LS_MAX consecutive load grants while it waits.
module rom_arbiter #(
    parameter int DEPTH_WORDS = 256,
    parameter int LS_MAX      = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    rom_arbiter_if.slave  bus
);
    localparam int SW = ($clog2(LS_MAX + 1) < 2) ? 2 : $clog2(LS_MAX + 1);

    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_LS} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  ls_streak_q, ls_streak_d;
    logic [31:0]    rom_addr_q, rom_addr_d;
    logic [31:0]    if_rdata_q, if_rdata_d;
    logic [31:0]    ls_rdata_q, ls_rdata_d;
    logic           if_err_q, if_err_d;
    logic           ls_err_q, ls_err_d;
    logic           if_gnt, ls_gnt, addr_err;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    always_comb begin
        state_d     = IDLE;
        ls_streak_d = ls_streak_q;
        rom_addr_d  = rom_addr_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_err_d    = 1'b0;
        ls_err_d    = 1'b0;

        // Grants are gated by reset so nothing is launched while reset is held.
        ls_gnt = reset_n && bus.ls_req && !(bus.if_req && ls_streak_q == SW'(LS_MAX));
        if_gnt = reset_n && bus.if_req && !ls_gnt;

        if (if_gnt)      rom_addr_d = bus.if_addr;
        else if (ls_gnt) rom_addr_d = bus.ls_addr;
        addr_err = bad_addr(rom_addr_d);

        if (if_gnt) begin
            state_d    = RESP_IF;
            if_err_d   = addr_err;
            if_rdata_d = addr_err ? 32'h0 : bus.rom_data;
        end else if (ls_gnt) begin
            state_d    = RESP_LS;
            ls_err_d   = addr_err;
            ls_rdata_d = addr_err ? 32'h0 : bus.rom_data;
        end

        if (!bus.if_req || if_gnt)
            ls_streak_d = '0;
        else if (ls_gnt && ls_streak_q < SW'(LS_MAX))
            ls_streak_d = ls_streak_q + SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ls_streak_q <= '0;
            rom_addr_q  <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ls_streak_q <= ls_streak_d;
            rom_addr_q  <= rom_addr_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_err_q    <= if_err_d;
            ls_err_q    <= ls_err_d;
        end
    end

    // The response state doubles as the one-cycle rvalid for whichever port was granted.
    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.rom_addr  = rom_addr_d;
    assign bus.if_rvalid = (state_q == RESP_IF);
    assign bus.ls_rvalid = (state_q == RESP_LS);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.ls_err    = ls_err_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: grants, responses, contention fairness, errors, reset.
module tb_rom_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    rom_arbiter_if bus();

    rom_arbiter #(.DEPTH_WORDS(256), .LS_MAX(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // ROM image: word 2 is a real instruction, every other word is tagged with its index.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [29:0] idx;
        idx = a[31:2];
        if (idx == 30'd2) return 32'h00A0_0093;
        return {16'hC0DE, idx[15:0]};
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.ls_req  = 1'b0;
        bus.ls_addr = 32'h0;
        #1;
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
        chk("rst_errs", {30'd0, bus.if_err, bus.ls_err}, 32'd0);
        chk("rst_rom_addr", bus.rom_addr, 32'h0);
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        #1;
        chk("rst_no_gnt", {30'd0, bus.if_gnt, bus.ls_gnt}, 32'd0);
        tick;
        tick;
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        reset_n    = 1'b1;
        #1;

        // Single fetch, first cycle after reset release.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h8;
        #1;
        chk("a_if_gnt", 32'(bus.if_gnt), 32'd1);
        chk("a_ls_gnt", 32'(bus.ls_gnt), 32'd0);
        chk("a_rom_addr", bus.rom_addr, 32'h8);
        tick;
        bus.if_req = 1'b0;
        chk("a_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("a_if_rdata", bus.if_rdata, 32'h00A0_0093);
        chk("a_if_err", 32'(bus.if_err), 32'd0);
        chk("a_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        #1;
        chk("a_no_gnt", 32'(bus.if_gnt), 32'd0);
        chk("a_rom_hold", bus.rom_addr, 32'h8);
        tick;
        chk("a_rvalid_drop", 32'(bus.if_rvalid), 32'd0);
        chk("a_rdata_hold", bus.if_rdata, 32'h00A0_0093);

        // Fetch streaming 0x0, 0x4, 0x8.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        #1;
        chk("s_gnt0", 32'(bus.if_gnt), 32'd1);
        tick;
        bus.if_addr = 32'h4;
        chk("s_rv0", 32'(bus.if_rvalid), 32'd1);
        chk("s_d0", bus.if_rdata, 32'hC0DE_0000);
        tick;
        bus.if_addr = 32'h8;
        chk("s_rv1", 32'(bus.if_rvalid), 32'd1);
        chk("s_d1", bus.if_rdata, 32'hC0DE_0001);
        tick;
        bus.if_req = 1'b0;
        chk("s_rv2", 32'(bus.if_rvalid), 32'd1);
        chk("s_d2", bus.if_rdata, 32'h00A0_0093);
        tick;
        chk("s_rv_end", 32'(bus.if_rvalid), 32'd0);

        // Contention: LS,LS,LS,IF repeating.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'hC;
        #1;
        for (int i = 0; i < 8; i++) begin
            logic exp_ls;
            exp_ls = (i % 4) != 3;
            chk($sformatf("c_ls_gnt%0d", i), 32'(bus.ls_gnt), 32'(exp_ls));
            chk($sformatf("c_if_gnt%0d", i), 32'(bus.if_gnt), 32'(!exp_ls));
            tick;
            chk($sformatf("c_ls_rv%0d", i), 32'(bus.ls_rvalid), 32'(exp_ls));
            chk($sformatf("c_if_rv%0d", i), 32'(bus.if_rvalid), 32'(!exp_ls));
            if (exp_ls) chk($sformatf("c_ls_d%0d", i), bus.ls_rdata, 32'hC0DE_0003);
            else        chk($sformatf("c_if_d%0d", i), bus.if_rdata, 32'hC0DE_0001);
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        tick;

        // Load errors: misaligned, past end, then last valid word.
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h6;
        #1;
        chk("e_gnt", 32'(bus.ls_gnt), 32'd1);
        tick;
        bus.ls_addr = 32'h400;
        chk("e1_rv", 32'(bus.ls_rvalid), 32'd1);
        chk("e1_err", 32'(bus.ls_err), 32'd1);
        chk("e1_data", bus.ls_rdata, 32'h0);
        chk("e1_if_rv", {30'd0, bus.if_rvalid, bus.if_err}, 32'd0);
        tick;
        bus.ls_addr = 32'h3FC;
        chk("e2_rv", 32'(bus.ls_rvalid), 32'd1);
        chk("e2_err", 32'(bus.ls_err), 32'd1);
        chk("e2_data", bus.ls_rdata, 32'h0);
        tick;
        bus.ls_req = 1'b0;
        chk("e3_rv", 32'(bus.ls_rvalid), 32'd1);
        chk("e3_err", 32'(bus.ls_err), 32'd0);
        chk("e3_data", bus.ls_rdata, 32'hC0DE_00FF);
        tick;
        chk("e_rv_end", 32'(bus.ls_rvalid), 32'd0);

        // Fetch withdraws while load wins.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'hC;
        #1;
        chk("w_if_gnt", 32'(bus.if_gnt), 32'd0);
        tick;
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        chk("w_streak1", 32'(dut.ls_streak_q), 32'd1);
        chk("w_if_rv", 32'(bus.if_rvalid), 32'd0);
        #1;
        chk("w_if_gnt2", 32'(bus.if_gnt), 32'd0);
        tick;
        chk("w_streak0", 32'(dut.ls_streak_q), 32'd0);
        chk("w_if_rv2", 32'(bus.if_rvalid), 32'd0);

        // Reset pulsed while a load grant is in flight.
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        #1;
        tick;
        chk("r_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("r_streak_pre", 32'(dut.ls_streak_q), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("r_gnts", {30'd0, bus.if_gnt, bus.ls_gnt}, 32'd0);
        chk("r_ls_rv", 32'(bus.ls_rvalid), 32'd0);
        chk("r_ls_data", bus.ls_rdata, 32'h0);
        chk("r_rom_addr", bus.rom_addr, 32'h0);
        chk("r_streak", 32'(dut.ls_streak_q), 32'd0);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        tick;
        chk("r_ls_rv2", 32'(bus.ls_rvalid), 32'd0);
        reset_n = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        #1;
        chk("r_first_gnt", 32'(bus.if_gnt), 32'd1);
        tick;
        bus.if_req = 1'b0;
        chk("r_first_rv", 32'(bus.if_rvalid), 32'd1);
        chk("r_first_d", bus.if_rdata, 32'hC0DE_0000);
        chk("r_ls_rv3", 32'(bus.ls_rvalid), 32'd0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
